// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the register-file RAM, with a registered write stage and
// read-port front end. Define REGFILE_WR_BYPASS_EN to forward the in-flight write to rd_data.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic {SrcA = 1'b0, SrcB = 1'b1} src_e;

    src_e                  rr_last_q, rr_last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  both_valid;
    logic                  grant_a, grant_b;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grants are gated by rst_n so nothing is accepted while the write stage is being cleared.
    always_comb begin
        both_valid = a_valid & b_valid;
        grant_a    = rst_n & a_valid & (~b_valid | (rr_last_q == SrcB));
        grant_b    = rst_n & b_valid & (~a_valid | (rr_last_q == SrcA));
        sel_addr   = grant_a ? a_addr : b_addr;
        sel_data   = grant_a ? a_data : b_data;
    end

    always_comb begin
        rr_last_d = rr_last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        if (grant_a || grant_b) begin
            // x0 writes are accepted but never reach the RAM.
            wr_en_d   = (sel_addr != '0);
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
        if (both_valid) begin
            rr_last_d = grant_a ? SrcA : SrcB;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q <= SrcB;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign ram_wr_en    = wr_en_q;
    assign ram_wr_addr  = wr_addr_q;
    assign ram_wr_data  = wr_data_q;
    assign ram_rd_en    = rd_en;
    assign ram_rd_addr  = rd_addr;
    assign conflict_cnt = cnt_q;

`ifdef REGFILE_WR_BYPASS_EN
    assign rd_data = (wr_en_q && (rd_addr == wr_addr_q)) ? wr_data_q : ram_rd_data;
`else
    assign rd_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table plus write-stage scoreboard,
// with a behavioural RAM attached to the write and read ports.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, ram_wr_addr, rd_addr, ram_rd_addr;
    logic [DW-1:0] a_data, b_data, ram_wr_data, ram_rd_data, rd_data;
    logic          ram_wr_en, rd_en, ram_rd_en;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .rd_data     (rd_data),
        .conflict_cnt(conflict_cnt)
    );

    // Behavioural register-file RAM: synchronous write, combinational read.
    logic [DW-1:0] mem [32];
    logic          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            init_done <= 1'b1;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
    end
    assign ram_rd_data = mem[ram_rd_addr];

    typedef struct {
        bit            rst;
        bit            av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        bit            bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        bit            ren;
        logic [AW-1:0] ra;
        bit            chk_rd;
        logic [DW-1:0] exp_rd;
        bit            exp_ar;
        bit            exp_br;
    } vec_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  q[$];

    int n_chk = 0;
    int n_err = 0;

    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;
    bit            cnt_known = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                                bit bv, logic [AW-1:0] ba, logic [DW-1:0] bd,
                                bit crd, logic [AW-1:0] ra, logic [DW-1:0] erd,
                                bit ear, bit ebr);
        vec_t v;
        v.rst = r;   v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv;   v.ba = ba; v.bd = bd;
        v.ren = crd; v.ra = ra; v.chk_rd = crd; v.exp_rd = erd;
        v.exp_ar = ear; v.exp_br = ebr;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t rd(logic [AW-1:0] ra, logic [DW-1:0] erd);
        return mk(1, 0, 0, 0, 0, 0, 0, 1, ra, erd, 0, 0);
    endfunction

    // One clock cycle: compare the write stage registered by the previous edge, drive the
    // vector, then compare combinational outputs before the next edge.
    task automatic step(input vec_t v);
        wr_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ram_wr_en", DW'(ram_wr_en), DW'(e.en));
            chk("ram_wr_addr", DW'(ram_wr_addr), DW'(e.addr));
            chk("ram_wr_data", ram_wr_data, e.data);
        end
        rst_n = v.rst; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        rd_en = v.ren; rd_addr = v.ra;
        @(negedge clk);
        chk("a_ready", DW'(a_ready), DW'(v.exp_ar));
        chk("b_ready", DW'(b_ready), DW'(v.exp_br));
        if (v.chk_rd) chk("rd_data", rd_data, v.exp_rd);
        if (v.rst && cnt_known) chk("conflict_cnt", DW'(conflict_cnt), DW'(m_cnt));
        if (!v.rst) begin
            m_en = 0; m_addr = 0; m_data = 0; m_cnt = 0; cnt_known = 1'b1;
        end else begin
            if (v.av && v.bv && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (v.exp_ar) begin
                m_en = (v.aa != 0); m_addr = v.aa; m_data = v.ad;
            end else if (v.exp_br) begin
                m_en = (v.ba != 0); m_addr = v.ba; m_data = v.bd;
            end else begin
                m_en = 0;
            end
        end
        q.push_back('{m_en, m_addr, m_data});
    endtask

    logic [DW-1:0] byp_exp;

    initial begin
        rst_n = 0; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0; rd_en = 0; rd_addr = 0;
`ifdef REGFILE_WR_BYPASS_EN
        byp_exp = 32'hCAFE;
`else
        byp_exp = 32'h1111;
`endif
        // Reset with both sources requesting
        vecs.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 0));
        // A-only write to x3, read back two cycles later
        vecs.push_back(mk(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle());
        vecs.push_back(rd(3, 32'hDEADBEEF));
        // First conflict goes to A, then B alone
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 0, 1));
        vecs.push_back(idle());
        // Continuous conflict: single-source grant left rr_last at A, so B first
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 1, 0));
        vecs.push_back(rd(2, 32'h22));
        // B writes x0: accepted, dropped
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 1));
        vecs.push_back(rd(0, 0));
        vecs.push_back(rd(0, 0));
        // x5 = 0x1111, then x5 = 0xCAFE with a read during the RAM write cycle
        vecs.push_back(mk(1, 1, 5, 32'h1111, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle());
        vecs.push_back(idle());
        vecs.push_back(mk(1, 1, 5, 32'hCAFE, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(rd(5, byp_exp));
        vecs.push_back(rd(5, 32'hCAFE));
        // Request during reset is not accepted; rr pointer returns to A-first
        vecs.push_back(mk(0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(rd(7, 0));
        vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 1, 0));
        vecs.push_back(idle());

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Saturation: 2^CW + 3 back-to-back conflict cycles, rr_last is A so B leads
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, (i % 2) == 1, (i % 2) == 0));
        end
        step(idle());
        step(idle());
        chk("conflict_cnt_sat", DW'(conflict_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
